// File: rtl/tetris_pkg.sv
// Button codes shared by the input controller, the command queue and the grid controller.
package tetris_pkg;

  localparam logic [3:0] BTN_NONE   = 4'd0;
  localparam logic [3:0] BTN_A      = 4'd1;
  localparam logic [3:0] BTN_B      = 4'd2;
  localparam logic [3:0] BTN_SELECT = 4'd3;
  localparam logic [3:0] BTN_START  = 4'd4;
  localparam logic [3:0] BTN_UP     = 4'd5;
  localparam logic [3:0] BTN_DOWN   = 4'd6;
  localparam logic [3:0] BTN_LEFT   = 4'd7;
  localparam logic [3:0] BTN_RIGHT  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  function automatic logic is_repeat_code(input logic [3:0] code);
    case (code)
      BTN_DOWN, BTN_LEFT, BTN_RIGHT: is_repeat_code = 1'b1;
      default:                       is_repeat_code = 1'b0;
    endcase
  endfunction

  // Out-of-range codes are indistinguishable from "nothing pressed".
  function automatic logic [3:0] sanitize_code(input logic [3:0] code);
    case (code)
      BTN_NONE, BTN_A, BTN_B, BTN_SELECT, BTN_START,
      BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT: sanitize_code = code;
      default:                               sanitize_code = BTN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO only
// succeeds when a pop frees a slot in the same cycle. Head reads 0 when empty.
module cmd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags, pointer advance and storage update.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    if (do_push_s) begin
      wr_ptr_d                    = wr_ptr_q + PTR_ONE;
      mem_d[wr_ptr_q[AW-1:0]]     = push_data;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (empty) begin
      head_data = {WIDTH{1'b0}};
    end else begin
      head_data = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {(AW + 1){1'b0}};
      rd_ptr_q <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/button_cmd_queue.sv
// Converts held controller button codes into one-shot move commands with
// release filtering and DAS/ARR auto-repeat, buffered in a small FIFO.
module button_cmd_queue
  import tetris_pkg::*;
#(
  parameter int RELEASE_CYCLES = 8192,
  parameter int DAS_CYCLES     = 13333333,
  parameter int ARR_CYCLES     = 2500000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] button_code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic       overflow,
  output logic [3:0] held_code
);
  localparam int TIMER_SPAN = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int TW = $clog2(TIMER_SPAN + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  localparam logic [TW-1:0] DAS_LAST   = TW'(DAS_CYCLES - 1);
  localparam logic [TW-1:0] ARR_LAST   = TW'(ARR_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TIMER_ONE  = {{(TW - 1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TIMER_SAT  = {TW{1'b1}};
  localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_CYCLES - 1);
  localparam logic [RW-1:0] REL_ZERO   = {RW{1'b0}};
  localparam logic [RW-1:0] REL_ONE    = {{(RW - 1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] REL_SAT    = {RW{1'b1}};

  btn_state_e    state_q, state_d;
  logic [3:0]    held_q, held_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rel_q, rel_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    code_s;
  logic          push_s;
  logic [3:0]    push_code_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  // Press/release/repeat decisions; a new press wins over release, release over repeat.
  always_comb begin
    code_s      = sanitize_code(button_code);
    state_d     = state_q;
    held_d      = held_q;
    timer_d     = timer_q;
    rel_d       = rel_q;
    push_s      = 1'b0;
    push_code_s = BTN_NONE;

    if (code_s != BTN_NONE) begin
      rel_d = REL_ZERO;
    end else if ((held_q != BTN_NONE) && (rel_q != REL_SAT)) begin
      rel_d = rel_q + REL_ONE;
    end else begin
      rel_d = rel_q;
    end

    if ((code_s != BTN_NONE) && (code_s != held_q)) begin
      push_s      = 1'b1;
      push_code_s = code_s;
      held_d      = code_s;
      timer_d     = TIMER_ZERO;
      rel_d       = REL_ZERO;
      state_d     = ST_HELD;
    end else if ((held_q != BTN_NONE) && (code_s == BTN_NONE) && (rel_q == REL_LAST)) begin
      held_d  = BTN_NONE;
      timer_d = TIMER_ZERO;
      rel_d   = REL_ZERO;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = TIMER_ZERO;
        end
        ST_HELD: begin
          if (!is_repeat_code(held_q)) begin
            timer_d = TIMER_ZERO;
          end else if (timer_q == DAS_LAST) begin
            push_s      = 1'b1;
            push_code_s = held_q;
            timer_d     = TIMER_ZERO;
            state_d     = ST_REPEAT;
          end else if (timer_q != TIMER_SAT) begin
            timer_d = timer_q + TIMER_ONE;
          end else begin
            timer_d = timer_q;
          end
        end
        ST_REPEAT: begin
          if (timer_q == ARR_LAST) begin
            push_s      = 1'b1;
            push_code_s = held_q;
            timer_d     = TIMER_ZERO;
          end else if (timer_q != TIMER_SAT) begin
            timer_d = timer_q + TIMER_ONE;
          end else begin
            timer_d = timer_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          held_d  = BTN_NONE;
          timer_d = TIMER_ZERO;
          rel_d   = REL_ZERO;
        end
      endcase
    end

    // A full FIFO frees a slot only when the consumer pops in the same cycle.
    overflow_d = push_s && fifo_full_s && !cmd_ready;
  end

  // State, timers and overflow pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      held_q     <= BTN_NONE;
      timer_q    <= TIMER_ZERO;
      rel_q      <= REL_ZERO;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      timer_q    <= timer_d;
      rel_q      <= rel_d;
      overflow_q <= overflow_d;
    end
  end

  cmd_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_code_s),
    .pop       (cmd_ready),
    .head_data (cmd_code),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign cmd_valid = !fifo_empty_s;
  assign overflow  = overflow_q;
  assign held_code = held_q;

endmodule

// File: tb/tb_button_cmd_queue.sv
// Directed bench for button_cmd_queue: expected commands (and, when popped
// immediately, their arrival cycle) are queued at stimulus time.
module tb_button_cmd_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] button_code;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       overflow;
  logic [3:0] held_code;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ovf_cnt  = 0;

  typedef struct {
    logic [3:0] code;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] seq [6];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  button_cmd_queue #(
    .RELEASE_CYCLES (16),
    .DAS_CYCLES     (20),
    .ARR_CYCLES     (5),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .button_code (button_code),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .overflow    (overflow),
    .held_code   (held_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_cmd(input logic [3:0] c, input bit timed);
    exp_t e;
    e.code = c;
    e.t    = timed ? cyc + 1 : -1;
    exp_q.push_back(e);
  endtask

  // Scoreboard side: runs on every falling edge the stimulus passes through.
  task automatic monitor();
    if (overflow === 1'b1) ovf_cnt++;
    if (reset_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_extra observed=%0d expected=none", cmd_code);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert (cmd_code === mon_e.code) else begin
          failures++;
          $error("FAIL sb_code observed=%0d expected=%0d", cmd_code, mon_e.code);
        end
        if (mon_e.t >= 0) begin
          checks++;
          assert (cyc === mon_e.t) else begin
            failures++;
            $error("FAIL sb_time code=%0d observed=%0d expected=%0d", mon_e.code, cyc, mon_e.t);
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    button_code = 4'd0;
    cmd_ready   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", cmd_valid, 32'd0);
    check("rst_code", cmd_code, 32'd0);
    check("rst_overflow", overflow, 32'd0);
    check("rst_held", held_code, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single press of A, then release after 16 zero cycles.
    expect_cmd(4'd1, 1'b1);
    button_code = 4'd1;
    tick(1);
    check("press_valid", cmd_valid, 32'd1);
    check("press_code", cmd_code, 32'd1);
    check("press_held", held_code, 32'd1);
    tick(9);
    button_code = 4'd0;
    tick(15);
    check("rel_15_held", held_code, 32'd1);
    tick(1);
    check("rel_16_held", held_code, 32'd0);
    tick(4);
    check("t1_sb_empty", exp_q.size(), 32'd0);

    // Left held through 8-cycle latch gaps: DAS at 20, ARR every 5.
    for (int i = 0; i < 102; i++) begin
      if (i == 30 || i == 60 || i == 90) check("gap_held", held_code, 32'd7);
      if (i == 0 || (i >= 20 && (i - 20) % 5 == 0)) expect_cmd(4'd7, 1'b1);
      button_code = ((i % 30) >= 22) ? 4'd0 : 4'd7;
      tick(1);
    end
    expect_cmd(4'd1, 1'b1);
    button_code = 4'd1;
    tick(3);
    button_code = 4'd0;
    tick(20);
    check("t2_held", held_code, 32'd0);
    check("t2_sb_empty", exp_q.size(), 32'd0);

    // Out-of-range code behaves as no button.
    button_code = 4'd12;
    tick(5);
    check("inv_held", held_code, 32'd0);
    check("inv_valid", cmd_valid, 32'd0);

    // Left then Right: immediate new press, DAS restarts for Right; then Start held.
    for (int i = 0; i < 42; i++) begin
      if (i == 10) check("sw_held", held_code, 32'd7);
      if (i == 0) expect_cmd(4'd7, 1'b1);
      if (i == 10 || (i >= 30 && i % 5 == 0)) expect_cmd(4'd8, 1'b1);
      button_code = (i < 10) ? 4'd7 : 4'd8;
      tick(1);
    end
    for (int i = 0; i < 200; i++) begin
      if (i == 0) expect_cmd(4'd4, 1'b1);
      button_code = 4'd4;
      tick(1);
    end
    check("start_held", held_code, 32'd4);
    button_code = 4'd0;
    tick(20);
    check("t4_held", held_code, 32'd0);
    check("t4_sb_empty", exp_q.size(), 32'd0);

    // Backpressure: six presses into a four-entry FIFO.
    cmd_ready = 1'b0;
    ovf_cnt   = 0;
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3;
    seq[3] = 4'd4; seq[4] = 4'd5; seq[5] = 4'd1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) expect_cmd(seq[k], 1'b0);
      button_code = seq[k];
      tick(1);
      check("ovf_pulse", overflow, (k >= 4) ? 32'd1 : 32'd0);
      check("bp_head", cmd_code, 32'd1);
      tick(1);
      check("ovf_clear", overflow, 32'd0);
    end
    check("bp_held", held_code, 32'd1);
    button_code = 4'd0;
    tick(20);
    check("bp_valid", cmd_valid, 32'd1);
    check("bp_head_stable", cmd_code, 32'd1);
    check("ovf_count", ovf_cnt, 32'd2);
    cmd_ready = 1'b1;
    tick(6);
    check("drain_valid", cmd_valid, 32'd0);
    check("drain_code", cmd_code, 32'd0);
    check("t5_sb_empty", exp_q.size(), 32'd0);

    // Async reset while repeating with two commands queued.
    cmd_ready = 1'b0;
    expect_cmd(4'd7, 1'b0);
    button_code = 4'd7;
    tick(20);
    expect_cmd(4'd7, 1'b0);
    tick(3);
    check("pre_rst_valid", cmd_valid, 32'd1);
    check("pre_rst_code", cmd_code, 32'd7);
    check("pre_rst_held", held_code, 32'd7);
    reset_n     = 1'b0;
    button_code = 4'd0;
    #1;
    check("arst_valid", cmd_valid, 32'd0);
    check("arst_held", held_code, 32'd0);
    check("arst_overflow", overflow, 32'd0);
    #2 reset_n = 1'b1;
    exp_q.delete();
    tick(5);
    check("post_rst_valid", cmd_valid, 32'd0);
    check("post_rst_code", cmd_code, 32'd0);
    check("post_rst_held", held_code, 32'd0);
    cmd_ready = 1'b1;
    tick(3);
    check("post_rst_empty", cmd_valid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_cmd_queue.md
Name: button_cmd_queue

Overview:
- Sits between the NES input controller and the grid controller.
- Turns the controller's 4-bit button code into discrete, one-shot move commands. The code is held per frame and cleared to 0 briefly at each latch.
- Handles press detection, release filtering and delayed auto-repeat (DAS/ARR) for Left, Right and Down.
- Buffers commands in a small FIFO that the grid controller drains with a valid/ready handshake.

Parameters:
- RELEASE_CYCLES, 8192: consecutive zero-code cycles before a held button counts as released. Must exceed the post-latch zero window (≤5100 cycles).
- DAS_CYCLES, 13333333: hold time before the first auto-repeat (~267 ms at 50 MHz).
- ARR_CYCLES, 2500000: interval between subsequent auto-repeats (50 ms).
- FIFO_DEPTH, 4: command buffer entries. Must be a power of 2, ≥2.

Ports:
- clk  input  1  50 MHz system clock
- reset_n  input  1  asynchronous, active-low reset
- button_code  input  4  code from input controller: 0 none, 1 A, 2 B, 3 Select, 4 Start, 5 Up, 6 Down, 7 Left, 8 Right
- cmd_ready  input  1  grid controller accepts the head command this cycle
- cmd_valid  output  1  FIFO non-empty
- cmd_code  output  4  head command code (1..8); 0 when empty
- overflow  output  1  one-cycle pulse when a command is dropped because the FIFO is full
- held_code  output  4  currently held button, 0 if none

Behaviour:
- Reset (async assert, sync release): FIFO empty, cmd_valid=0, cmd_code=0, overflow=0, held_code=0, all counters 0, FSM in IDLE.
- Codes 9..15 are treated as 0.
- FSM states:
  - IDLE: held_code=0.
  - HELD: button down; non-repeating codes, or repeating codes before the DAS expires.
  - REPEAT: auto-repeat running.
- Press event:
  - Trigger: button_code≠0 and button_code≠held_code.
  - Action: push button_code, held_code<=button_code, zero timer and release counter.
  - Next state: HELD.
  - Applies in any state, so a switch between buttons yields a new press immediately.
- Release filter:
  - Any cycle with button_code≠0 zeroes the release counter.
  - While held_code≠0 and button_code==0, the counter increments.
  - When it reaches RELEASE_CYCLES-1: held_code<=0, go to IDLE, no command pushed.
  - The timer keeps running during short zero windows. A latch gap therefore does not restart DAS.
- Auto-repeat (held_code in {6,7,8} only):
  - HELD: timer counts each cycle. At DAS_CYCLES-1, push held_code, zero timer, go to REPEAT.
  - REPEAT: at ARR_CYCLES-1, push held_code, zero timer.
  - Codes 1-5 never repeat; they stay in HELD until release or a different press.
- Push latency: the command is visible at cmd_valid/cmd_code one cycle after the triggering input cycle.
- Handshake:
  - A pop occurs when cmd_valid && cmd_ready.
  - cmd_code is stable while cmd_valid=1 and cmd_ready=0.
- FIFO boundaries:
  - Push when full without a same-cycle pop: command dropped, overflow=1 for one cycle, contents unchanged.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Pop when empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full/empty come from the MSB compare.
- Counter widths: $clog2(max(DAS_CYCLES,ARR_CYCLES)+1) and $clog2(RELEASE_CYCLES+1). Counters saturate and never wrap.

Decomposition:
- Shared package tetris_pkg holds:
  - localparams BTN_NONE..BTN_RIGHT (0..8);
  - function is_repeat_code(code).
- The input controller and grid controller import the same codes.
- One natural sub-module: cmd_fifo, a parameterised synchronous FIFO with push/pop/full/empty, width 4 and depth FIFO_DEPTH.

Test Plan (bench parameters RELEASE_CYCLES=16, DAS_CYCLES=20, ARR_CYCLES=5, FIFO_DEPTH=4, cmd_ready=1 unless stated):
- Single press: code 1 for 10 cycles, then 0 for 20 → exactly one command 1, cmd_valid high one cycle later; held_code returns to 0 16 zero-cycles after release.
- Latch gap: code 7 with 8-cycle zero gaps every 30 cycles, held 100 cycles → one press command, then a repeat 7 at 20 cycles, then every 5 cycles; no spurious releases or re-presses.
- Button switch: code 7 held 10 cycles, then code 8 → commands 7 then 8 back-to-back; DAS restarts for 8.
- Non-repeat: code 4 held 200 cycles → exactly one command 4.
- Backpressure/overflow: cmd_ready=0, six distinct presses → FIFO holds the first four in order, overflow pulses twice; then cmd_ready=1 → four commands drained in order, cmd_code=0 after.
- Async reset mid-repeat: reset_n low for 3 ns during REPEAT with 2 queued commands → cmd_valid, held_code and overflow go 0 immediately; the FIFO is empty after release.
